// File: rtl/sipo_capture_pkg.sv
// Shared definitions for the serial capture stage and the upstream rotating shifter.
package sipo_capture_pkg;

  // Capture FSM states, 2-bit encoding.
  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StArmed = 2'b01,
    StShift = 2'b10
  } state_e;

  // Default tick divider; the upstream shifter imports this too so both stages agree on rate.
  localparam int unsigned DefaultDiv = 50_000_000;

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sipo_capture_tick_gen.sv
// Free-running divider producing a one-cycle enable every DIV clk cycles.
module tick_gen
  import sipo_capture_pkg::*;
#(
  parameter int unsigned DIV = DefaultDiv
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int unsigned CntW = cnt_width(DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(DIV - 1);

  logic [CntW-1:0] cnt_q;

  // Count 0..DIV-1 and wrap; the tick is the cycle spent at the top value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (cnt_q == CntLast) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(1);
    end
  end

  // Decoded straight from the counter so reset drops it immediately.
  always_comb begin
    tick = (cnt_q == CntLast);
  end

endmodule

// File: rtl/sipo_capture.sv
// Serial-in parallel-out capture of the upstream shifter's MSB stream, MSB first,
// with a valid/ack handshake, sticky overrun and the shared tick divider.
module sipo_capture
  import sipo_capture_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIV   = DefaultDiv,
  parameter int unsigned CONT  = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     sin,
  input  logic                     ack,
  output logic                     tick_o,
  output logic [WIDTH-1:0]         data,
  output logic                     valid,
  output logic                     busy,
  output logic                     overrun,
  output logic [$clog2(WIDTH)-1:0] bit_cnt
);

  localparam int unsigned CntW = $clog2(WIDTH);
  localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shreg_q;
  logic [CntW-1:0]  bit_cnt_q;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             overrun_q;
  logic             busy_q;

  logic             tick;
  logic [WIDTH-1:0] frame_next;
  logic             last_bit;
  logic             complete;

  tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  // Shift-in value, last-bit decode and frame completion strobe; stop wins over completion.
  always_comb begin
    frame_next = {shreg_q[WIDTH-2:0], sin};
    last_bit   = (bit_cnt_q == LastBit);
    complete   = 1'b0;
    if ((state_q == StShift) && tick && last_bit && !stop) begin
      complete = 1'b1;
    end
  end

  // Capture FSM, shift register, bit counter and handshake with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      // ack consumes the held frame; a completion on the same edge re-raises valid below.
      if (ack) begin
        valid_q   <= 1'b0;
        overrun_q <= 1'b0;
      end
      if (complete) begin
        data_q  <= frame_next;
        valid_q <= 1'b1;
        if (valid_q && !ack) begin
          overrun_q <= 1'b1;
        end
      end

      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q <= StArmed;
            busy_q  <= 1'b1;
          end
        end
        StArmed: begin
          // The first tick only aligns capture to a full tick period; no bit is taken.
          if (stop) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
          end else if (tick) begin
            state_q <= StShift;
          end
        end
        StShift: begin
          if (stop) begin
            state_q   <= StIdle;
            busy_q    <= 1'b0;
            shreg_q   <= '0;
            bit_cnt_q <= '0;
          end else if (tick) begin
            shreg_q <= frame_next;
            if (last_bit) begin
              bit_cnt_q <= '0;
              if (CONT == 0) begin
                state_q <= StIdle;
                busy_q  <= 1'b0;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + CntW'(1);
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    tick_o  = tick;
    data    = data_q;
    valid   = valid_q;
    busy    = busy_q;
    overrun = overrun_q;
    bit_cnt = bit_cnt_q;
  end

endmodule

// File: tb/tb_sipo_capture.sv
// Bench for sipo_capture: one single-frame and one continuous instance, scoreboard of
// expected frames checked by a monitor whenever a new frame is presented.
module tb_sipo_capture;

  localparam int unsigned W = 8;
  localparam int unsigned D = 4;

  typedef struct {
    logic [W-1:0] data;
    logic         ovr;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         sin = 1'b0;
  logic         start_v [2];
  logic         stop_v  [2];
  logic         ack_v   [2];
  logic         tick_v  [2];
  logic         valid_v [2];
  logic         busy_v  [2];
  logic         ovr_v   [2];
  logic [W-1:0] data_v  [2];
  logic [2:0]   cnt_v   [2];

  int total = 0;
  int bad   = 0;

  exp_t q0[$];
  exp_t q1[$];
  exp_t e_m;

  // Reference model of the consumer-visible state per instance.
  logic         mv [2];
  logic         mo [2];
  logic [W-1:0] md [2];

  // Monitor history.
  logic         pv [2];
  logic [W-1:0] pd [2];

  always #5 clk = ~clk;

  sipo_capture #(.WIDTH(W), .DIV(D), .CONT(0)) u_dut0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_v[0]),
    .stop    (stop_v[0]),
    .sin     (sin),
    .ack     (ack_v[0]),
    .tick_o  (tick_v[0]),
    .data    (data_v[0]),
    .valid   (valid_v[0]),
    .busy    (busy_v[0]),
    .overrun (ovr_v[0]),
    .bit_cnt (cnt_v[0])
  );

  sipo_capture #(.WIDTH(W), .DIV(D), .CONT(1)) u_dut1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start_v[1]),
    .stop    (stop_v[1]),
    .sin     (sin),
    .ack     (ack_v[1]),
    .tick_o  (tick_v[1]),
    .data    (data_v[1]),
    .valid   (valid_v[1]),
    .busy    (busy_v[1]),
    .overrun (ovr_v[1]),
    .bit_cnt (cnt_v[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: a frame is presented when valid rises or the held data changes.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst_n && valid_v[k] && (!pv[k] || data_v[k] != pd[k])) begin
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
          total++;
          bad++;
          $display("FAIL mon%0d_unexpected: got %0h want none", k, data_v[k]);
        end else begin
          if (k == 0) e_m = q0.pop_front();
          else        e_m = q1.pop_front();
          chk($sformatf("mon%0d_data", k), 32'(data_v[k]), 32'(e_m.data));
          chk($sformatf("mon%0d_ovr", k), 32'(ovr_v[k]), 32'(e_m.ovr));
        end
      end
      pv[k] <= rst_n ? valid_v[k] : 1'b0;
      pd[k] <= rst_n ? data_v[k] : '0;
    end
  end

  task automatic wait_tick(input int w);
    int n = 0;
    while (!tick_v[w] && n < 3 * D) begin
      @(negedge clk);
      n++;
    end
    chk("tick_wait", 32'(tick_v[w]), 32'd1);
  endtask

  // Present one bit on the next tick, optionally acking in that same cycle.
  task automatic send_bit(input int w, input logic b, input logic do_ack);
    wait_tick(w);
    sin = b;
    if (do_ack) ack_v[w] = 1'b1;
    @(negedge clk);
    ack_v[w] = 1'b0;
    sin = 1'($urandom);
  endtask

  task automatic send_frame(input int w, input logic [W-1:0] d, input logic ack_last);
    exp_t e;
    for (int i = W - 1; i >= 0; i--) begin
      if (i == 0) begin
        e.data = d;
        e.ovr  = ack_last ? 1'b0 : (mv[w] ? 1'b1 : mo[w]);
        if (w == 0) q0.push_back(e);
        else        q1.push_back(e);
        mv[w] = 1'b1;
        mo[w] = e.ovr;
        md[w] = d;
      end
      send_bit(w, d[i], ack_last && (i == 0));
    end
  endtask

  task automatic do_start(input int w);
    start_v[w] = 1'b1;
    @(negedge clk);
    start_v[w] = 1'b0;
  endtask

  task automatic do_ack(input int w);
    ack_v[w] = 1'b1;
    @(negedge clk);
    ack_v[w] = 1'b0;
    mv[w] = 1'b0;
    mo[w] = 1'b0;
  endtask

  task automatic do_stop(input int w);
    stop_v[w] = 1'b1;
    @(negedge clk);
    stop_v[w] = 1'b0;
  endtask

  task automatic capture(input int w, input logic [W-1:0] d);
    do_start(w);
    send_bit(w, 1'($urandom), 1'b0);  // arming tick carries no data
    send_frame(w, d, 1'b0);
  endtask

  initial begin
    logic [W-1:0] d;
    for (int k = 0; k < 2; k++) begin
      start_v[k] = 1'b0; stop_v[k] = 1'b0; ack_v[k] = 1'b0;
      mv[k] = 1'b0; mo[k] = 1'b0; md[k] = '0;
    end

    // Reset state.
    repeat (3) @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      chk("rst_tick", 32'(tick_v[k]), 0);
      chk("rst_data", 32'(data_v[k]), 0);
      chk("rst_valid", 32'(valid_v[k]), 0);
      chk("rst_busy", 32'(busy_v[k]), 0);
      chk("rst_ovr", 32'(ovr_v[k]), 0);
      chk("rst_cnt", 32'(cnt_v[k]), 0);
    end
    rst_n = 1'b1;

    // Idle tick cadence: high in every DIV-th cycle after release.
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      chk($sformatf("idle_tick_c%0d", c), 32'(tick_v[0]), 32'((c % D) == D - 1));
    end
    chk("idle_valid", 32'(valid_v[0]), 0);
    chk("idle_busy", 32'(busy_v[0]), 0);

    // Single frame A5.
    capture(0, 8'hA5);
    chk("a5_valid", 32'(valid_v[0]), 1);
    chk("a5_busy", 32'(busy_v[0]), 0);
    chk("a5_data", 32'(data_v[0]), 32'hA5);
    repeat (3) @(negedge clk);
    chk("a5_hold", 32'(valid_v[0]), 1);
    do_ack(0);
    chk("a5_acked", 32'(valid_v[0]), 0);

    // Continuous: two frames without ack sets overrun.
    do_start(1);
    send_bit(1, 1'($urandom), 1'b0);
    send_frame(1, 8'h3C, 1'b0);
    send_frame(1, 8'hC3, 1'b0);
    chk("ovr_data", 32'(data_v[1]), 32'hC3);
    chk("ovr_valid", 32'(valid_v[1]), 1);
    chk("ovr_flag", 32'(ovr_v[1]), 1);
    chk("ovr_busy", 32'(busy_v[1]), 1);
    do_ack(1);
    chk("ovr_ack_valid", 32'(valid_v[1]), 0);
    chk("ovr_ack_flag", 32'(ovr_v[1]), 0);
    do_stop(1);
    chk("cont_stop_busy", 32'(busy_v[1]), 0);
    chk("cont_stop_cnt", 32'(cnt_v[1]), 0);

    // Continuous: ack in the completion cycle of the second frame.
    do_start(1);
    send_bit(1, 1'($urandom), 1'b0);
    send_frame(1, 8'h3C, 1'b0);
    send_frame(1, 8'hC3, 1'b1);
    chk("ackc_data", 32'(data_v[1]), 32'hC3);
    chk("ackc_valid", 32'(valid_v[1]), 1);
    chk("ackc_ovr", 32'(ovr_v[1]), 0);
    do_ack(1);
    do_stop(1);

    // Stop mid-frame leaves the held frame alone and discards partial bits.
    capture(0, 8'($urandom));
    do_start(0);
    send_bit(0, 1'($urandom), 1'b0);
    for (int i = 0; i < 3; i++) send_bit(0, 1'($urandom), 1'b0);
    chk("stop_pre_cnt", 32'(cnt_v[0]), 3);
    chk("stop_pre_busy", 32'(busy_v[0]), 1);
    do_stop(0);
    chk("stop_busy", 32'(busy_v[0]), 0);
    chk("stop_cnt", 32'(cnt_v[0]), 0);
    chk("stop_valid", 32'(valid_v[0]), 1);
    chk("stop_data", 32'(data_v[0]), 32'(md[0]));
    do_ack(0);
    capture(0, 8'h0F);
    chk("post_stop_data", 32'(data_v[0]), 32'h0F);

    // Random frames with random acks; unacked frames must raise overrun.
    for (int n = 0; n < 6; n++) begin
      if (mv[0] && $urandom_range(0, 1) == 1) do_ack(0);
      d = 8'($urandom);
      if (mv[0] && d == md[0]) d = ~d;
      capture(0, d);
      chk("rnd_ovr", 32'(ovr_v[0]), 32'(mo[0]));
    end

    // Asynchronous reset in the 5th data tick of a frame, with a frame held.
    if (mv[0]) do_ack(0);
    capture(0, 8'h5A);
    do_start(0);
    send_bit(0, 1'($urandom), 1'b0);
    for (int i = 0; i < 4; i++) send_bit(0, 1'($urandom), 1'b0);
    wait_tick(0);
    sin = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("arst_data", 32'(data_v[0]), 0);
    chk("arst_valid", 32'(valid_v[0]), 0);
    chk("arst_busy", 32'(busy_v[0]), 0);
    chk("arst_ovr", 32'(ovr_v[0]), 0);
    chk("arst_cnt", 32'(cnt_v[0]), 0);
    chk("arst_tick", 32'(tick_v[0]), 0);
    for (int k = 0; k < 2; k++) begin
      mv[k] = 1'b0; mo[k] = 1'b0; md[k] = '0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    capture(0, 8'hFF);
    chk("arst_ff", 32'(data_v[0]), 32'hFF);

    repeat (2) @(negedge clk);
    chk("q0_drained", 32'(q0.size()), 0);
    chk("q1_drained", 32'(q1.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
